// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, sticky overflow/underflow errors and an optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] PTR_ONE = PW'(1);

  // Pointers carry one extra MSB so a full FIFO is distinguishable from an empty one.
  logic [AW:0]           w_ptr_q, w_ptr_d;
  logic [AW:0]           r_ptr_q, r_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [AW-1:0]         r_idx, w_idx;

  assign r_idx = r_ptr_q[AW-1:0];
  assign w_idx = w_ptr_q[AW-1:0];

  // Flags come straight from the registered pointers: no extra latency.
  assign count        = w_ptr_q - r_ptr_q;
  assign full         = (count == PW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PW'(AF_THRESH));
  assign almost_empty = (count <= PW'(AE_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_acc) r_ptr_d = r_ptr_q + PTR_ONE;
    // A new error event in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || (wr_en && full);
    unf_d = (unf_q && !clr_err) || (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[w_idx] <= data_in;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rvld_q, rvld_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = mem_q[r_idx];
      rvld_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
        rvld_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        rvld_q <= rvld_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rvld_q;
  end else begin : g_fwft
    // Head word is presented directly; zero while empty so reset reads back 0.
    assign data_out = empty ? '0 : mem_q[r_idx];
    assign rd_valid = !empty;
  end

endmodule
